// File: rtl/pd_debug_pkg.sv
// Shared types and helpers for the pattern-generator debug trace RAM.
// Capture FSM encoding is visible to firmware through the state port.
`ifndef PD_DEBUG_PKG_SV
`define PD_DEBUG_PKG_SV

`define PD_PARAM_CHECK(blk_name, cond) \
    if (!(cond)) begin : blk_name \
        $error("pd_debug: parameter check failed: cond"); \
    end

package pd_debug_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic int pd_lanes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

`endif

// File: rtl/pd_dp_ram_be.sv
// Single-clock dual-port RAM with byte enables on both ports.
// Port A has a registered read returning old data on read-during-write.
module pd_dp_ram_be
    import pd_debug_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   a_addr_i,
    input  logic [DATA_W/8-1:0] a_be_i,
    input  logic                a_we_i,
    input  logic [DATA_W-1:0]   a_wdata_i,
    output logic [DATA_W-1:0]   a_rdata_o,
    input  logic [ADDR_W-1:0]   b_addr_i,
    input  logic [DATA_W/8-1:0] b_be_i,
    input  logic                b_we_i,
    input  logic [DATA_W-1:0]   b_wdata_i
);
    localparam int LANES = pd_lanes(DATA_W);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] a_rdata_q;

    // Port B is applied last so it would win a same-address clash.
    always_ff @(posedge clk) begin
        for (int b = 0; b < LANES; b++) begin
            if (a_we_i && a_be_i[b]) begin
                mem[a_addr_i][8*b +: 8] <= a_wdata_i[8*b +: 8];
            end
        end
        for (int b = 0; b < LANES; b++) begin
            if (b_we_i && b_be_i[b]) begin
                mem[b_addr_i][8*b +: 8] <= b_wdata_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_rdata_q <= '0;
        end else begin
            a_rdata_q <= mem[a_addr_i];
        end
    end

    assign a_rdata_o = a_rdata_q;

endmodule

// File: rtl/pd_debug_trace_ram.sv
// Debug trace RAM: CPU Avalon-MM port plus a circular capture port that
// freezes POST_TRIG samples after a trigger.
module pd_debug_trace_ram
    import pd_debug_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int POST_TRIG = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W/8-1:0] byteenable,
    input  logic                chipselect,
    input  logic                write,
    input  logic [DATA_W-1:0]   writedata,
    output logic [DATA_W-1:0]   readdata,
    input  logic                sample_valid,
    input  logic [DATA_W-1:0]   sample_data,
    input  logic                arm,
    input  logic                trigger,
    input  logic                abort,
    input  logic                freeze,
    output logic [1:0]          state,
    output logic [ADDR_W-1:0]   wr_ptr,
    output logic [ADDR_W-1:0]   trig_ptr,
    output logic                wrapped,
    output logic                done,
    output logic                collision
);
    localparam int LANES = pd_lanes(DATA_W);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] POST_CNT_INIT = ADDR_W'(POST_TRIG);

    `PD_PARAM_CHECK(g_chk_data_w, (DATA_W % 8) == 0)
    `PD_PARAM_CHECK(g_chk_post_trig, (POST_TRIG >= 0) && (POST_TRIG <= DEPTH - 1))

    state_e            state_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] trig_ptr_q;
    logic [ADDR_W-1:0] post_cnt_q;
    logic              wrapped_q;
    logic              collision_q;

    logic capturing;
    logic cs_wr;
    logic cpu_wr;
    logic coll_hit;

    assign capturing = (state_q == ST_ARMED) || (state_q == ST_POST);
    assign cs_wr     = sample_valid & ~freeze & ~abort & ~reset & capturing;
    assign cpu_wr    = chipselect & write;
    assign coll_hit  = cpu_wr & cs_wr & (address == wr_ptr_q);

    pd_dp_ram_be #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .reset     (reset),
        .a_addr_i  (address),
        .a_be_i    (byteenable),
        .a_we_i    (cpu_wr & ~coll_hit),
        .a_wdata_i (writedata),
        .a_rdata_o (readdata),
        .b_addr_i  (wr_ptr_q),
        .b_be_i    ({LANES{1'b1}}),
        .b_we_i    (cs_wr),
        .b_wdata_i (sample_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            trig_ptr_q  <= '0;
            post_cnt_q  <= '0;
            wrapped_q   <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            collision_q <= coll_hit;
            if (abort) begin
                state_q <= ST_IDLE;
            end else if (!freeze) begin
                if (cs_wr) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                    if (&wr_ptr_q) wrapped_q <= 1'b1;
                end
                // arm restarts from any state; its pointer reset overrides the increment above
                if (arm) begin
                    state_q   <= ST_ARMED;
                    wr_ptr_q  <= '0;
                    wrapped_q <= 1'b0;
                end else begin
                    case (state_q)
                        ST_ARMED: begin
                            if (trigger) begin
                                trig_ptr_q <= wr_ptr_q;
                                post_cnt_q <= POST_CNT_INIT;
                                state_q    <= (POST_TRIG == 0) ? ST_DONE : ST_POST;
                            end
                        end
                        ST_POST: begin
                            if (cs_wr) begin
                                post_cnt_q <= post_cnt_q - 1'b1;
                                if (post_cnt_q == ADDR_W'(1)) state_q <= ST_DONE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign state     = state_q;
    assign wr_ptr    = wr_ptr_q;
    assign trig_ptr  = trig_ptr_q;
    assign wrapped   = wrapped_q;
    assign done      = (state_q == ST_DONE);
    assign collision = collision_q;

endmodule

// File: tb/tb_pd_debug_trace_ram.sv
// Self-checking bench for pd_debug_trace_ram: per-cycle model compare plus
// directed scenarios with literal expectations.
module tb_pd_debug_trace_ram;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 4;
    localparam int POST_TRIG = 4;
    localparam int DEPTH     = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  address;
    logic [3:0]  byteenable;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        sample_valid;
    logic [31:0] sample_data;
    logic        arm;
    logic        trigger;
    logic        abort;
    logic        freeze;
    logic [1:0]  state;
    logic [3:0]  wr_ptr;
    logic [3:0]  trig_ptr;
    logic        wrapped;
    logic        done;
    logic        collision;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    pd_debug_trace_ram #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .POST_TRIG (POST_TRIG)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .byteenable   (byteenable),
        .chipselect   (chipselect),
        .write        (write),
        .writedata    (writedata),
        .readdata     (readdata),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .arm          (arm),
        .trigger      (trigger),
        .abort        (abort),
        .freeze       (freeze),
        .state        (state),
        .wr_ptr       (wr_ptr),
        .trig_ptr     (trig_ptr),
        .wrapped      (wrapped),
        .done         (done),
        .collision    (collision)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: state numbers 0..3, pointers as plain ints.
    logic [31:0] m_mem [DEPTH];
    bit          m_set [DEPTH];
    int          m_st, m_wp, m_tp, m_post;
    bit          m_wrap, m_coll;
    logic [31:0] rd_exp;
    bit          rd_known;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_set[i] = 1'b0;
        end
        m_st = 0; m_wp = 0; m_tp = 0; m_post = 0;
        m_wrap = 0; m_coll = 0; rd_exp = '0; rd_known = 1'b0;
    end

    always @(posedge clk) begin
        int  a, old_wp;
        bit  capt, cpu, hit;
        a      = int'(address);
        old_wp = m_wp;
        capt   = !reset && sample_valid && !freeze && !abort && (m_st == 1 || m_st == 2);
        cpu    = chipselect && write;
        hit    = cpu && capt && (a == m_wp);
        if (reset) begin
            rd_exp = '0;
            rd_known = 1'b1;
        end else begin
            rd_exp = m_mem[a];
            rd_known = m_set[a];
        end
        if (cpu && !hit) begin
            for (int b = 0; b < 4; b++)
                if (byteenable[b]) m_mem[a][8*b +: 8] = writedata[8*b +: 8];
            if (byteenable == 4'hF) m_set[a] = 1'b1;
        end
        if (capt) begin
            m_mem[m_wp] = sample_data;
            m_set[m_wp] = 1'b1;
        end
        if (reset) begin
            m_st = 0; m_wp = 0; m_tp = 0; m_post = 0; m_wrap = 0; m_coll = 0;
        end else begin
            m_coll = hit;
            if (abort) begin
                m_st = 0;
            end else if (!freeze) begin
                if (capt) begin
                    m_wp = (m_wp + 1) % DEPTH;
                    if (m_wp == 0) m_wrap = 1;
                end
                if (arm) begin
                    m_st = 1; m_wp = 0; m_wrap = 0;
                end else if (m_st == 1 && trigger) begin
                    m_tp = old_wp;
                    m_post = POST_TRIG;
                    m_st = (POST_TRIG == 0) ? 3 : 2;
                end else if (m_st == 2 && capt) begin
                    m_post = m_post - 1;
                    if (m_post == 0) m_st = 3;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("state", 32'(state), 32'(m_st));
            check("wr_ptr", 32'(wr_ptr), 32'(m_wp));
            check("trig_ptr", 32'(trig_ptr), 32'(m_tp));
            check("wrapped", 32'(wrapped), 32'(m_wrap));
            check("done", 32'(done), 32'(m_st == 3));
            check("collision", 32'(collision), 32'(m_coll));
            if (rd_known) check("readdata", readdata, rd_exp);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic clr();
        reset = 0; address = '0; byteenable = '0; chipselect = 0; write = 0;
        writedata = '0; sample_valid = 0; sample_data = '0; arm = 0;
        trigger = 0; abort = 0; freeze = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        clr();
    endtask

    task automatic cpu_wr(input int a, input logic [31:0] d, input logic [3:0] be);
        chipselect = 1; write = 1; address = 4'(a); writedata = d; byteenable = be;
    endtask

    task automatic smp(input logic [31:0] d);
        sample_valid = 1; sample_data = d;
    endtask

    task automatic rd(input int a, input logic [31:0] exp, input string name);
        chipselect = 1; address = 4'(a);
        tick();
        check(name, readdata, exp);
    endtask

    initial begin
        clr();
        reset = 1;
        tick();
        chk_en = 1'b1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_wr_ptr", 32'(wr_ptr), 32'd0);
        check("rst_readdata", readdata, 32'd0);
        check("rst_done", 32'(done), 32'd0);

        // 1: byte-enabled writes
        cpu_wr(3, 32'hDEADBEEF, 4'hF); tick();
        cpu_wr(3, 32'h0000AA00, 4'b0010); tick();
        rd(3, 32'hDEADAAEF, "t1_be_merge");

        // 2: basic trigger, no wrap
        arm = 1; tick();
        check("t2_armed", 32'(state), 32'd1);
        for (int i = 0; i < 5; i++) begin smp(32'h100 + i); tick(); end
        smp(32'h105); trigger = 1; tick();
        check("t2_post", 32'(state), 32'd2);
        for (int i = 6; i < 10; i++) begin smp(32'h100 + i); tick(); end
        check("t2_done_state", 32'(state), 32'd3);
        check("t2_trig_ptr", 32'(trig_ptr), 32'd5);
        check("t2_wr_ptr", 32'(wr_ptr), 32'd10);
        check("t2_wrapped", 32'(wrapped), 32'd0);
        check("t2_done", 32'(done), 32'd1);
        smp(32'hAAA); tick();
        check("t2_no_write_done", 32'(wr_ptr), 32'd10);
        rd(5, 32'h105, "t2_rd5");

        // 3: wrap before trigger
        arm = 1; tick();
        for (int i = 0; i < 18; i++) begin smp(32'(i)); tick(); end
        smp(32'h12); trigger = 1; tick();
        check("t3_trig_ptr", 32'(trig_ptr), 32'd2);
        check("t3_wrapped", 32'(wrapped), 32'd1);
        for (int i = 0; i < 4; i++) begin smp(32'h13 + i); tick(); end
        check("t3_wr_ptr", 32'(wr_ptr), 32'd7);
        check("t3_done", 32'(state), 32'd3);
        rd(2, 32'h12, "t3_rd2");

        // 4: freeze in POST
        arm = 1; tick();
        smp(32'h200); trigger = 1; tick();
        smp(32'h201); tick();
        freeze = 1; smp(32'hBAD0); arm = 1; tick();
        check("t4_arm_ignored", 32'(state), 32'd2);
        freeze = 1; smp(32'hBAD1); chipselect = 1; address = 4'd2; tick();
        check("t4_cpu_rd_frozen", readdata, 32'h12);
        freeze = 1; smp(32'hBAD2); tick();
        check("t4_wr_ptr_hold", 32'(wr_ptr), 32'd2);
        smp(32'h202); tick();
        smp(32'h203); tick();
        check("t4_still_post", 32'(state), 32'd2);
        smp(32'h204); tick();
        check("t4_done", 32'(state), 32'd3);
        rd(2, 32'h202, "t4_rd2");

        // 5: collision same address, then different address
        arm = 1; tick();
        for (int i = 0; i < 6; i++) begin smp(32'h300 + i); tick(); end
        cpu_wr(6, 32'hFFFFFFFF, 4'hF); smp(32'h55); tick();
        check("t5_collision", 32'(collision), 32'd1);
        rd(6, 32'h55, "t5_rd6");
        check("t5_coll_pulse", 32'(collision), 32'd0);
        arm = 1; tick();
        for (int i = 0; i < 6; i++) begin smp(32'h310 + i); tick(); end
        cpu_wr(7, 32'hCAFEF00D, 4'hF); smp(32'h56); tick();
        check("t5_no_collision", 32'(collision), 32'd0);
        rd(6, 32'h56, "t5_rd6b");
        rd(7, 32'hCAFEF00D, "t5_rd7");

        // abort holds pointers
        arm = 1; tick();
        smp(32'h500); tick();
        smp(32'h501); abort = 1; tick();
        check("abort_state", 32'(state), 32'd0);
        check("abort_wr_ptr", 32'(wr_ptr), 32'd1);

        // 6: reset mid-POST
        arm = 1; tick();
        smp(32'h400); trigger = 1; tick();
        smp(32'h401); tick();
        check("t6_in_post", 32'(state), 32'd2);
        reset = 1; tick();
        check("t6_state", 32'(state), 32'd0);
        check("t6_wr_ptr", 32'(wr_ptr), 32'd0);
        check("t6_trig_ptr", 32'(trig_ptr), 32'd0);
        check("t6_wrapped", 32'(wrapped), 32'd0);
        check("t6_readdata", readdata, 32'd0);
        rd(0, 32'h400, "t6_rd0");
        rd(1, 32'h401, "t6_rd1");

        tick();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pd_debug_trace_ram.md
Name: pd_debug_trace_ram

Overview:
Parametrised single-clock debug RAM for the pattern-generator subsystem. Port A is an Avalon-MM slave used by the CPU for byte-enabled read/write. Port B is a hardware capture port that writes samples into the RAM as a circular trace buffer. An arm/trigger/post-trigger state machine freezes the trace a fixed number of samples after a trigger, so firmware can read back the history around the event.

Parameters:
DATA_W, 32, word width in bits; must be a multiple of 8.
ADDR_W, 4, address width; DEPTH = 2**ADDR_W words.
POST_TRIG, 8, samples captured after the trigger sample; elaboration error unless 0 <= POST_TRIG <= DEPTH-1.

Ports:
clk  in  1  single clock for all logic and both RAM ports
reset  in  1  synchronous, active-high
address  in  ADDR_W  CPU word address
byteenable  in  DATA_W/8  CPU byte lanes
chipselect  in  1  CPU select
write  in  1  CPU write strobe; effective write = chipselect & write
writedata  in  DATA_W  CPU write data
readdata  out  DATA_W  CPU read data, registered
sample_valid  in  1  capture sample strobe
sample_data  in  DATA_W  capture word, always written on all lanes
arm  in  1  single-cycle pulse; starts or restarts a capture
trigger  in  1  trigger event
abort  in  1  return to IDLE
freeze  in  1  level; suspends the capture path
state  out  2  0 = IDLE, 1 = ARMED, 2 = POST, 3 = DONE
wr_ptr  out  ADDR_W  next capture address
trig_ptr  out  ADDR_W  address holding the trigger sample
wrapped  out  1  buffer has wrapped since arm
done  out  1  high when state = DONE
collision  out  1  one-cycle pulse on a dropped CPU write

Behaviour:
- Reset value of every output and register: readdata 0, state IDLE, wr_ptr 0, trig_ptr 0, wrapped 0, done 0, collision 0. RAM contents are not cleared.
- Control priority, highest first: reset > abort > freeze > arm > trigger.
- CPU read: readdata <= mem[address] every clock; latency is 1 cycle.
- CPU write: only lanes with byteenable set are written.
- Read-during-write to the same address on port A returns the old data.
- Capture write (cs_wr): sample_valid & ~freeze & state in {ARMED, POST}. Writes mem[wr_ptr] <= sample_data on all lanes, then wr_ptr <= wr_ptr+1 modulo DEPTH.
- wrapped: set when wr_ptr wraps from DEPTH-1 to 0.
- Collision: a CPU write and cs_wr to the same address in the same cycle. The capture write wins, the whole CPU write is dropped, and collision pulses for 1 cycle.
- Collision on different addresses: both writes complete.
- IDLE: arm -> ARMED, with wr_ptr <= 0 and wrapped <= 0.
- ARMED:
  - trigger -> POST with post_cnt <= POST_TRIG; if POST_TRIG = 0, go directly to DONE.
  - trig_ptr <= wr_ptr. This is the trigger sample's address if sample_valid is high that cycle, otherwise the next sample's address.
  - A sample and trigger in the same cycle are both honoured.
- POST: post_cnt decrements on each cs_wr; the write that brings post_cnt to 0 moves the state to DONE in the same edge. trigger is ignored.
- DONE: no capture writes; done = 1. arm -> ARMED (restart).
- arm in ARMED or POST restarts: wr_ptr <= 0, wrapped <= 0, state ARMED.
- freeze high: no capture writes, pointers and post_cnt hold, state holds, arm and trigger are ignored. CPU port is unaffected.
- abort: any state -> IDLE. Pointers and wrapped hold so firmware can inspect them.
- Reset mid-capture: behaves exactly as power-on reset; RAM contents survive.
- post_cnt width: ADDR_W bits.

Decomposition:
- Package pd_debug_pkg holds:
  - state enum (IDLE, ARMED, POST, DONE) with its 2-bit encoding;
  - a byte-lane-count function DATA_W/8;
  - a parameter-check macro.
- Sub-module pd_dp_ram_be: single-clock true dual-port RAM with per-port byte enables, 1-cycle registered port-A read, old-data read-during-write.
- The top level holds the FSM, pointers and collision arbitration.

Test Plan:
All scenarios use DATA_W=32, ADDR_W=4, POST_TRIG=4.
1. CPU writes 0xDEADBEEF to addr 3 with be=1111, then 0x0000AA00 to addr 3 with be=0010; read addr 3 -> readdata = 0xDEADAAEF one cycle after the address.
2. arm; samples 0x100..0x104; trigger together with sample 0x105; samples 0x106..0x109 -> state DONE on the 0x109 write, trig_ptr=5, wr_ptr=10, wrapped=0; CPU read of addr 5 = 0x105; an 11th sample is not written.
3. arm; 18 samples 0x0..0x11; trigger with sample 0x12 -> trig_ptr=2, wrapped=1; after 4 more samples wr_ptr=7 and addr 2 reads 0x12.
4. In POST with post_cnt=3, freeze high for 3 cycles with sample_valid high -> wr_ptr unchanged, no RAM change, DONE arrives 3 cycles later than without freeze; an arm during freeze is ignored.
5. In ARMED with wr_ptr=6, CPU writes 0xFFFFFFFF to addr 6 in the same cycle as sample 0x55 -> addr 6 reads 0x55 and collision=1 for one cycle. CPU write to addr 7 in the same cycle -> both succeed, no collision.
6. Reset asserted mid-POST -> next cycle all outputs are at their reset values and state = IDLE; addresses written before the reset still read back their sample data.
